layer_composer_n: RTL

- Parametrised next-generation display composer: merges NUM_LAYERS tile/bitmap line buffers and one sprite line buffer into a single pixel stream for the display timing unit.
- Sprite Z priority generalises to NUM_LAYERS+1 levels.
- Owns the scaled X/Y fetch counters, line IRQ, scanline report and interlace field tracking.
- Output pixel is registered (one-cycle pipeline) for timing closure at higher layer counts.

---
 rtl/layer_composer_n.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/layer_composer_n.sv
// Display composer: merges NUM_LAYERS background line buffers plus one sprite line
// buffer into a registered pixel stream, and owns scaled fetch counters, line IRQ and field tracking.
module layer_composer_n #(
    parameter int NUM_LAYERS = 2,
    parameter int PIX_W      = 8,
    parameter int HW         = 10,
    parameter int VW         = 9,
    parameter int FRAC_W     = 8,
    parameter int FRAC_BITS  = 7,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ZW         = $clog2(NUM_LAYERS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        interlaced,
    input  logic [FRAC_W-1:0]           frac_x_incr,
    input  logic [FRAC_W-1:0]           frac_y_incr,
    input  logic [PIX_W-1:0]            border_color,
    input  logic [HW-1:0]               active_hstart,
    input  logic [HW-1:0]               active_hstop,
    input  logic [VW-1:0]               active_vstart,
    input  logic [VW-1:0]               active_vstop,
    input  logic [VW-1:0]               irqline,
    input  logic [NUM_LAYERS-1:0]       layer_enabled,
    input  logic                        sprites_enabled,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_lb_rddata,
    input  logic [PIX_W+ZW-1:0]         sprite_lb_rddata,
    input  logic                        display_next_frame,
    input  logic                        display_next_line,
    input  logic                        display_next_pixel,
    input  logic                        display_current_field,
    output logic                        current_field,
    output logic                        line_irq,
    output logic [VW-1:0]               scanline,
    output logic [VW-1:0]               line_idx,
    output logic                        line_render_start,
    output logic [HW-1:0]               lb_rdidx,
    output logic                        sprite_lb_erase_start,
    output logic [PIX_W-1:0]            display_data
);

    localparam int SXW = HW + FRAC_BITS;
    localparam int SYW = VW + FRAC_BITS;
    localparam logic [HW-1:0] H_MAX  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_MAX  = VW'(V_ACTIVE);

    logic [HW:0]        x_cnt_q, x_cnt_d;
    logic [VW:0]        y_cnt_q, y_cnt_d;
    logic [VW:0]        y_prev_q, y_prev_d;
    logic               field_q, field_d;
    logic               line_irq_q, line_r_q, started_q, started_d;
    logic               render_q, render_d, display_active_q;
    logic [SXW-1:0]     sx_q, sx_d;
    logic [SYW-1:0]     sy_q, sy_d;
    logic [PIX_W-1:0]   display_data_q, compose_pix;

    logic [HW-1:0]      x_pos;
    logic               hactive, vactive, irq_hit;
    logic [SXW-1:0]     sx_step;
    logic [SYW-1:0]     sy_step;

    assign x_pos   = x_cnt_q[HW:1];
    assign hactive = (x_pos >= active_hstart) && (x_pos < active_hstop);
    assign vactive = (y_prev_q >= {1'b0, active_vstart}) && (y_prev_q < {1'b0, active_vstop});
    // Interlaced lines advance y by two, so only the line pair is compared.
    assign irq_hit = interlaced ? (y_cnt_q[VW:1] == {1'b0, irqline[VW-1:1]})
                                : (y_cnt_q == {1'b0, irqline});
    assign sx_step = interlaced ? SXW'(frac_x_incr[FRAC_W-1:1]) : SXW'(frac_x_incr);
    assign sy_step = interlaced ? SYW'({frac_y_incr, 1'b0}) : SYW'(frac_y_incr);

    always_comb begin
        x_cnt_d  = x_cnt_q;
        y_cnt_d  = y_cnt_q;
        y_prev_d = y_prev_q;
        field_d  = field_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        started_d = started_q;
        render_d  = 1'b0;

        if (display_next_line) begin
            x_cnt_d = '0;
            sx_d    = '0;
        end else if (display_next_pixel) begin
            x_cnt_d = x_cnt_q + (interlaced ? (HW+1)'(1) : (HW+1)'(2));
            if (hactive && (sx_q[SXW-1:FRAC_BITS] < H_MAX)) begin
                sx_d = sx_q + sx_step;
            end
        end

        if (display_next_frame) begin
            y_cnt_d  = (interlaced && !display_current_field) ? (VW+1)'(1) : '0;
            y_prev_d = y_cnt_q;
            field_d  = !display_current_field;
        end else if (display_next_line) begin
            y_cnt_d  = y_cnt_q + (interlaced ? (VW+1)'(2) : (VW+1)'(1));
            y_prev_d = y_cnt_q;
        end

        // Vertical scaling runs one cycle after the line strobe, on settled y counters.
        if (display_next_frame) begin
            started_d = 1'b0;
        end else if (line_r_q) begin
            if (!started_q && (y_cnt_q >= {1'b0, active_vstart})) begin
                started_d = 1'b1;
                render_d  = 1'b1;
                sy_d = (interlaced && (field_q ^ active_vstart[0])) ? SYW'(frac_y_incr) : '0;
            end else if (started_q && (sy_q[SYW-1:FRAC_BITS] < V_MAX) && vactive) begin
                render_d = 1'b1;
                sy_d     = sy_q + sy_step;
            end
        end
    end

    logic [PIX_W-1:0] layer_pix [NUM_LAYERS+1];
    logic [ZW-1:0]    sprite_z;
    logic [PIX_W-1:0] sprite_pix;
    logic             sprite_ok;

    assign sprite_z   = sprite_lb_rddata[PIX_W +: ZW];
    assign sprite_pix = sprite_lb_rddata[PIX_W-1:0];
    assign sprite_ok  = sprites_enabled && (sprite_pix != '0);

    // Disabled layers read as transparent; the extra top slot is the sprite-only level.
    genvar gi;
    generate
        for (gi = 0; gi <= NUM_LAYERS; gi++) begin : g_layer
            if (gi < NUM_LAYERS) begin : g_real
                assign layer_pix[gi] = layer_enabled[gi] ? layer_lb_rddata[gi*PIX_W +: PIX_W] : '0;
            end else begin : g_top
                assign layer_pix[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        compose_pix = '0;
        if (!display_active_q) begin
            compose_pix = border_color;
        end else begin
            for (int k = 0; k <= NUM_LAYERS; k++) begin
                if (sprite_ok && (32'(sprite_z) == 32'(k + 1))) begin
                    compose_pix = sprite_pix;
                end
                if (layer_pix[k] != '0) begin
                    compose_pix = layer_pix[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt_q          <= '0;
            y_cnt_q          <= '0;
            y_prev_q         <= '0;
            field_q          <= 1'b0;
            line_irq_q       <= 1'b0;
            line_r_q         <= 1'b0;
            started_q        <= 1'b0;
            render_q         <= 1'b0;
            display_active_q <= 1'b0;
            sx_q             <= '0;
            sy_q             <= '0;
            display_data_q   <= '0;
        end else begin
            x_cnt_q          <= x_cnt_d;
            y_cnt_q          <= y_cnt_d;
            y_prev_q         <= y_prev_d;
            field_q          <= field_d;
            line_irq_q       <= display_next_line && irq_hit;
            line_r_q         <= display_next_line;
            started_q        <= started_d;
            render_q         <= render_d;
            display_active_q <= hactive && vactive;
            sx_q             <= sx_d;
            sy_q             <= sy_d;
            display_data_q   <= compose_pix;
        end
    end

    assign current_field         = field_q;
    assign line_irq              = line_irq_q;
    assign scanline              = y_prev_q[VW] ? '1 : y_cnt_q[VW-1:0];
    assign line_idx              = sy_q[SYW-1:FRAC_BITS];
    assign line_render_start     = render_q;
    assign lb_rdidx              = sx_q[SXW-1:FRAC_BITS];
    assign sprite_lb_erase_start = (x_cnt_q == {H_LAST, interlaced});
    assign display_data          = display_data_q;

endmodule
